// File: rtl/palette_pkg.sv
// Shared types and constants for the palette controller.
// Default palette, FSM states and the per-channel dim helper.
package palette_pkg;

  localparam int NUM_ENTRIES = 16;
  localparam int INDEX_W     = 4;
  localparam int COLOR_W     = 9;
  localparam int CH_W        = 3;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [INDEX_W-1:0] index_t;
  typedef logic [CH_W-1:0]    chan_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    COPY
  } state_e;

  localparam index_t LAST_IDX = INDEX_W'(NUM_ENTRIES - 1);

  localparam color_t DEFAULT_PAL [NUM_ENTRIES] = '{
    9'h000, 9'h027, 9'h00B, 9'h078,
    9'h0CF, 9'h124, 9'h1C0, 9'h1CC,
    9'h1E0, 9'h1E4, 9'h1E7, 9'h1F4,
    9'h1F8, 9'h1FF, 9'h000, 9'h000
  };

  function automatic chan_t sat_sub(
    input chan_t ch,
    input chan_t d
  );
    return (ch > d) ? chan_t'(ch - d) : '0;
  endfunction

endpackage

// File: rtl/palette_if.sv
// Host-side shadow write and commit port.
// master = host, slave = palette_controller.
interface palette_if;
  import palette_pkg::*;

  logic   i_wr_valid;
  logic   o_wr_ready;
  index_t i_wr_index;
  color_t i_wr_color;
  logic   i_commit;
  logic   o_commit_busy;

  modport master (
    output i_wr_valid,
    output i_wr_index,
    output i_wr_color,
    output i_commit,
    input  o_wr_ready,
    input  o_commit_busy
  );

  modport slave (
    input  i_wr_valid,
    input  i_wr_index,
    input  i_wr_color,
    input  i_commit,
    output o_wr_ready,
    output o_commit_busy
  );

endinterface

// File: rtl/palette_dim.sv
// Saturating per-channel brightness reduction.
// Dim 0 passes through, dim 7 forces black.
module palette_dim
  import palette_pkg::*;
(
  input  color_t color_i,
  input  chan_t  dim_i,
  output color_t color_o
);

  assign color_o = {
    sat_sub(color_i[8:6], dim_i),
    sat_sub(color_i[5:3], dim_i),
    sat_sub(color_i[2:0], dim_i)
  };

endmodule

// File: rtl/palette_controller.sv
// Shadow/active palette with vblank-synchronised commit copy.
// Lookup is registered and dimmed by the per-frame dim value.
module palette_controller
  import palette_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_reset,
  palette_if.slave       wr,
  input  logic           i_vblank,
  input  chan_t          i_dim,
  input  index_t         i_index,
  output color_t         o_color
);

  state_e state_q, state_d;
  index_t cnt_q, cnt_d;
  logic   vb_q;
  chan_t  dim_q;
  color_t color_q;
  color_t shadow_q [NUM_ENTRIES];
  color_t active_q [NUM_ENTRIES];

  logic   rise;
  logic   wr_fire;
  logic   copy_en;
  color_t look;
  color_t dimmed;

  assign rise    = i_vblank && !vb_q;
  assign wr_fire = wr.i_wr_valid && wr.o_wr_ready;
  assign look    = active_q[i_index];

  assign wr.o_wr_ready    = (state_q != COPY);
  assign wr.o_commit_busy = (state_q != IDLE);
  assign o_color          = color_q;

  palette_dim u_dim (
    .color_i (look),
    .dim_i   (dim_q),
    .color_o (dimmed)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    copy_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr.i_commit) state_d = WAIT;
      end
      WAIT: begin
        if (rise) begin
          state_d = COPY;
          cnt_d   = '0;
        end
      end
      COPY: begin
        copy_en = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vb_q    <= 1'b0;
      dim_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vb_q    <= i_vblank;
      if (rise) dim_q <= i_dim;
      color_q <= dimmed;
    end
  end

  // Copy reads the pre-edge shadow; writes are blocked during COPY anyway.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        shadow_q[i] <= DEFAULT_PAL[i];
        active_q[i] <= DEFAULT_PAL[i];
      end
    end else begin
      if (wr_fire) shadow_q[wr.i_wr_index] <= wr.i_wr_color;
      if (copy_en) active_q[cnt_q] <= shadow_q[cnt_q];
    end
  end

endmodule

// File: tb/tb_palette_controller.sv
// Directed bench for palette_controller.
// Expected colors are hand-computed from the default palette and dim rule.
module tb_palette_controller;
  import palette_pkg::*;

  logic   clk;
  logic   rst;
  logic   vblank;
  chan_t  dim;
  index_t idx;
  color_t color;

  int n_cmp;
  int n_bad;

  palette_if wr_if ();

  palette_controller dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .wr       (wr_if.slave),
    .i_vblank (vblank),
    .i_dim    (dim),
    .i_index  (idx),
    .o_color  (color)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] got,
                     input logic [8:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    vblank = 1'b0;
    dim = '0;
    idx = '0;
    wr_if.i_wr_valid = 1'b0;
    wr_if.i_wr_index = '0;
    wr_if.i_wr_color = '0;
    wr_if.i_commit = 1'b0;
    step();
    step();
    chk("rst_color", color, 9'h000);
    chk("rst_ready", 9'(wr_if.o_wr_ready), 9'd1);
    chk("rst_busy", 9'(wr_if.o_commit_busy), 9'd0);
    rst = 1'b0;

    idx = 4'd1;
    step();
    chk("lookup_1", color, 9'h027);
    idx = 4'd13;
    step();
    chk("lookup_13", color, 9'h1FF);

    // shadow write then commit waiting for vblank
    wr_if.i_wr_valid = 1'b1;
    wr_if.i_wr_index = 4'd2;
    wr_if.i_wr_color = 9'h1FF;
    step();
    wr_if.i_wr_valid = 1'b0;
    wr_if.i_commit = 1'b1;
    step();
    wr_if.i_commit = 1'b0;
    idx = 4'd2;
    step();
    step();
    chk("wait_busy", 9'(wr_if.o_commit_busy), 9'd1);
    chk("wait_shadow_hidden", color, 9'h00B);
    vblank = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("copy_busy_%0d", k), 9'(wr_if.o_commit_busy), 9'd1);
      step();
    end
    chk("copy_done_busy", 9'(wr_if.o_commit_busy), 9'd0);
    chk("commit_idx2", color, 9'h1FF);

    // dim 2 then dim 7
    vblank = 1'b0;
    step();
    dim = 3'd2;
    idx = 4'd13;
    vblank = 1'b1;
    step();
    chk("dim_lag", color, 9'h1FF);
    step();
    chk("dim2_idx13", color, 9'h16D);
    idx = 4'd3;
    step();
    chk("dim2_idx3", color, 9'h028);
    idx = 4'd13;
    vblank = 1'b0;
    step();
    dim = 3'd7;
    vblank = 1'b1;
    step();
    step();
    chk("dim7_idx13", color, 9'h000);
    vblank = 1'b0;
    step();
    dim = 3'd0;
    vblank = 1'b1;
    step();
    step();
    chk("dim0_idx13", color, 9'h1FF);
    vblank = 1'b0;
    step();

    // write and commit in the same IDLE cycle
    wr_if.i_wr_valid = 1'b1;
    wr_if.i_wr_index = 4'd5;
    wr_if.i_wr_color = 9'h0AA;
    wr_if.i_commit = 1'b1;
    chk("idle_ready", 9'(wr_if.o_wr_ready), 9'd1);
    step();
    wr_if.i_wr_valid = 1'b0;
    wr_if.i_commit = 1'b0;
    idx = 4'd5;
    step();
    chk("wait_idx5_old", color, 9'h124);
    vblank = 1'b1;
    step();
    wr_if.i_wr_valid = 1'b1;
    wr_if.i_wr_index = 4'd6;
    wr_if.i_wr_color = 9'h155;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("copy_ready_%0d", k), 9'(wr_if.o_wr_ready), 9'd0);
      step();
    end
    chk("post_copy_ready", 9'(wr_if.o_wr_ready), 9'd1);
    step();
    wr_if.i_wr_valid = 1'b0;
    chk("commit_idx5", color, 9'h0AA);
    idx = 4'd6;
    step();
    chk("blocked_write_idx6", color, 9'h1C0);

    // commit the late write to entry 6
    vblank = 1'b0;
    wr_if.i_commit = 1'b1;
    step();
    wr_if.i_commit = 1'b0;
    vblank = 1'b1;
    step();
    repeat (16) step();
    chk("second_commit_busy", 9'(wr_if.o_commit_busy), 9'd0);
    chk("late_write_idx6", color, 9'h155);

    // reset in the middle of COPY
    vblank = 1'b0;
    wr_if.i_commit = 1'b1;
    step();
    wr_if.i_commit = 1'b0;
    vblank = 1'b1;
    step();
    repeat (8) step();
    chk("mid_copy_busy", 9'(wr_if.o_commit_busy), 9'd1);
    rst = 1'b1;
    step();
    chk("reset_busy", 9'(wr_if.o_commit_busy), 9'd0);
    chk("reset_ready", 9'(wr_if.o_wr_ready), 9'd1);
    chk("reset_color", color, 9'h000);
    rst = 1'b0;
    idx = 4'd2;
    step();
    chk("reset_idx2", color, 9'h00B);
    chk("reset_no_pending", 9'(wr_if.o_commit_busy), 9'd0);
    idx = 4'd5;
    step();
    chk("reset_idx5", color, 9'h124);
    idx = 4'd6;
    step();
    chk("reset_idx6", color, 9'h1C0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/palette_controller.md
# palette_controller

Owns a writable 16-entry, 9-bit (RRRGGGBBB) color palette for the VGA pixel path. Host writes go into a shadow palette through a valid/ready port. A commit request copies shadow to active palette, one entry per cycle, starting at the next vertical-blanking rising edge so the visible frame never tears. It also applies a per-frame brightness dim to every looked-up color, and replaces the fixed combinational palette between the bitmap index source and the RGB output stage.

## Interface
Parameters:
- NUM_ENTRIES, 16, palette depth (fixed at 16 in this revision)
- INDEX_W, 4, palette index width
- COLOR_W, 9, color width, 3 bits per channel (R = [8:6], G = [5:3], B = [2:0])

Ports:
- i_clk  in  1  system (pixel) clock; one clock domain
- i_reset  in  1  synchronous, active-high reset
- i_wr_valid  in  1  host shadow-write request
- o_wr_ready  out  1  shadow write accepted when valid && ready
- i_wr_index  in  INDEX_W  shadow entry to write
- i_wr_color  in  COLOR_W  color to write
- i_commit  in  1  single-cycle pulse requesting shadow-to-active commit
- o_commit_busy  out  1  high from accepted commit until copy finishes
- i_vblank  in  1  level, high during vertical blanking
- i_dim  in  3  brightness reduction 0..7, sampled at vblank rising edge
- i_index  in  INDEX_W  pixel lookup index
- o_color  out  COLOR_W  dimmed active color, registered

## Operation
- Default palette, applied to both shadow and active at reset: 0:000, 1:027, 2:00B, 3:078, 4:0CF, 5:124, 6:1C0, 7:1CC, 8:1E0, 9:1E4, 10:1E7, 11:1F4, 12:1F8, 13:1FF, 14:000, 15:000 (hex).
- Reset values: o_color = 0, o_wr_ready = 1, o_commit_busy = 0, dim register = 0, state IDLE, vblank edge register = 0.
- Vblank edge: register i_vblank; rise = i_vblank && !prev.
- The state machine has three states:
  - IDLE: i_commit goes to WAIT.
  - WAIT: on rise, go to COPY with copy counter = 0.
  - COPY: active[cnt] <= shadow[cnt]; cnt increments each cycle; after entry 15, go to IDLE. COPY lasts exactly 16 cycles.
- o_commit_busy = (state != IDLE).
- o_wr_ready = (state != COPY). Accepted writes update the shadow at the clock edge.
- A write and i_commit in the same IDLE cycle: the write is accepted and is included in the commit.
- i_commit while in WAIT or COPY is ignored. It does not queue.
- A rise with no pending commit updates the dim register only.
- Dim register <= i_dim on every rise, in every state.
- Dim rule: each channel out = (ch > dim) ? ch - dim : 0. Saturating. Dim 0 is pass-through and dim 7 gives black.
- Lookup reads the active palette only. The shadow is never visible on o_color.

## Timing
- Lookup latency is 1 cycle: o_color(n+1) = dim(active[i_index(n)]), using the dim register value at cycle n.
- Reads are read-before-write. A lookup of the entry being copied in the same cycle returns the old value. The new value is visible from the next cycle.
- A commit accepted at cycle c with a rise at cycle r > c gives COPY in cycles r+1 .. r+16. o_commit_busy falls at r+17.
- A rise in the same cycle as i_commit does not start the copy. The next rise is required.
- A dim change takes effect on o_color 2 cycles after the rise cycle: register, then the output register.
- Reset asserted mid-COPY or mid-WAIT: next cycle is IDLE, both palettes are default, the pending commit is discarded, and outputs are at their reset values.

## Structure
- Shared package palette_pkg holds:
  - COLOR_W, INDEX_W, NUM_ENTRIES
  - the 16-entry default palette constant array
  - the state enum {IDLE, WAIT, COPY}
- Sub-module palette_dim: combinational, 9-bit color plus 3-bit dim in, saturating per-channel subtract, 9-bit out.
- Shadow and active palettes are register arrays with a 16-way read mux. No RAM inference is required.

## Test plan
- Reset, then i_index = 1: o_color = 027 one cycle later. i_index = 13 gives 1FF.
- Write index 2 = 1FF, pulse i_commit, no vblank: busy stays high and o_color for index 2 stays 00B. After a vblank rise, busy is high for 16 COPY cycles, then index 2 reads 1FF.
- i_dim = 2 sampled at a rise, index 13: o_color = 16D two cycles after the rise. i_dim = 7 gives 000.
- Hold i_wr_valid during COPY: o_wr_ready = 0 and the shadow is unchanged. The write is accepted on the first cycle after COPY ends.
- Write and i_commit in the same IDLE cycle, with index 5 = 0AA: the committed active entry 5 = 0AA.
- Assert i_reset at COPY cycle 8: next cycle is IDLE with busy = 0, and all entries read the defaults (index 2 = 00B).
